// File: rtl/mem_bus_arbiter_if.sv
// Requester handshakes plus SRAM/UART strobes for the memory bus arbiter.
// The master modport is the arbiter; the slave modport is the CPU-side and memory-side environment.
interface mem_bus_arbiter_if;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_ack;
    logic [15:0] if_rdata;

    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ack;
    logic [15:0] d_rdata;

    logic        busy;
    logic [17:0] sram_addr;
    logic        sram_en;
    logic        sram_oe;
    logic        sram_rw;

    logic        tbre;
    logic        tsre;
    logic        data_ready;
    logic        rdn;
    logic        wrn;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, tbre, tsre, data_ready,
        output if_ack, if_rdata, d_ack, d_rdata, busy, sram_addr, sram_en, sram_oe,
               sram_rw, rdn, wrn
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, tbre, tsre, data_ready,
        input  if_ack, if_rdata, d_ack, d_rdata, busy, sram_addr, sram_en, sram_oe,
               sram_rw, rdn, wrn
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM/UART bus between instruction fetch and MEM-stage data accesses,
// with data priority softened by a one-grant fairness flag.
module mem_bus_arbiter #(
    parameter int          WAIT      = 1,
    parameter logic [15:0] UART_DATA = 16'hBF00,
    parameter logic [15:0] UART_STAT = 16'hBF01
) (
    input  logic               CLK,
    input  logic               RST,
    mem_bus_arbiter_if.master  bus,
    inout  wire  [15:0]        sram_data
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] MRD  = 3'd1;
    localparam logic [2:0] MWR  = 3'd2;
    localparam logic [2:0] URD  = 3'd3;
    localparam logic [2:0] UWR  = 3'd4;
    localparam logic [2:0] ACK  = 3'd5;

    localparam logic [2:0] WAIT_C = 3'(WAIT);

    logic [2:0]  state;
    logic [2:0]  cnt;
    logic        gnt_data;
    logic        last_data;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] if_rdata_q;
    logic [15:0] d_rdata_q;
    logic        pick_data;
    logic        pick_if;
    logic        last_beat;
    logic        drive;

    // Data normally wins; fetch takes its turn when the previous grant went to data.
    always_comb begin
        pick_data = bus.d_req && !(bus.if_req && last_data);
        pick_if   = bus.if_req && !pick_data;
    end

    assign last_beat = (cnt == WAIT_C);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            gnt_data   <= 1'b0;
            last_data  <= 1'b0;
            addr_q     <= 16'h0000;
            if_rdata_q <= 16'h0000;
            d_rdata_q  <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= 3'd0;
                    if (pick_data) begin
                        gnt_data  <= 1'b1;
                        last_data <= 1'b1;
                        addr_q    <= bus.d_addr;
                        if (bus.d_addr == UART_STAT) begin
                            state <= ACK;
                            if (!bus.d_we)
                                d_rdata_q <= {14'b0, bus.data_ready, bus.tbre & bus.tsre};
                        end else if (bus.d_addr == UART_DATA) begin
                            state <= bus.d_we ? UWR : URD;
                        end else begin
                            state <= bus.d_we ? MWR : MRD;
                        end
                    end else if (pick_if) begin
                        gnt_data  <= 1'b0;
                        last_data <= 1'b0;
                        addr_q    <= bus.if_addr;
                        state     <= MRD;
                    end
                end
                MRD, MWR, URD, UWR: begin
                    if (last_beat) begin
                        state <= ACK;
                        cnt   <= 3'd0;
                        if (state == MRD) begin
                            if (gnt_data)
                                d_rdata_q <= sram_data;
                            else
                                if_rdata_q <= sram_data;
                        end
                        if (state == URD)
                            d_rdata_q <= {8'h00, sram_data[7:0]};
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                ACK: begin
                    state <= IDLE;
                    cnt   <= 3'd0;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 3'd0;
                end
            endcase
        end
    end

    // Write data is only meaningful while driven, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (state == IDLE && pick_data)
            wdata_q <= bus.d_wdata;
    end

    always_comb begin
        bus.sram_en = 1'b1;
        bus.sram_oe = 1'b1;
        bus.sram_rw = 1'b1;
        bus.rdn     = 1'b1;
        bus.wrn     = 1'b1;
        drive       = 1'b0;
        case (state)
            MRD: begin
                bus.sram_en = 1'b0;
                bus.sram_oe = 1'b0;
            end
            MWR: begin
                bus.sram_en = 1'b0;
                // Address settles for one cycle before the write pulse, unless there is no slack.
                bus.sram_rw = (cnt == 3'd0) && (WAIT_C != 3'd0);
                drive       = 1'b1;
            end
            URD: bus.rdn = 1'b0;
            UWR: begin
                bus.wrn = 1'b0;
                drive   = 1'b1;
            end
            default: ;
        endcase
    end

    assign sram_data     = drive ? wdata_q : 16'hzzzz;
    assign bus.if_ack    = (state == ACK) && !gnt_data;
    assign bus.d_ack     = (state == ACK) && gnt_data;
    assign bus.busy      = (state != IDLE);
    assign bus.sram_addr = {2'b00, addr_q};
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios with literal expectations, then random traffic
// compared every cycle against a transaction-level script model.
module tb_mem_bus_arbiter;
    localparam int          WAIT      = 1;
    localparam logic [15:0] UART_DATA = 16'hBF00;
    localparam logic [15:0] UART_STAT = 16'hBF01;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] rd_val = 16'h0000;
    logic        tb_drv = 1'b1;
    wire  [15:0] sram_data;

    int checks = 0;
    int failures = 0;

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter #(.WAIT(WAIT), .UART_DATA(UART_DATA), .UART_STAT(UART_STAT)) dut (
        .CLK       (clk),
        .RST       (rst),
        .bus       (bus),
        .sram_data (sram_data)
    );

    // Memory/UART side: the bench owns the bus whenever the arbiter should not be driving it.
    assign sram_data = tb_drv ? rd_val : 16'hzzzz;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // One expected cycle: strb = {en, oe, rw, rdn, wrn}, ack = {if_ack, d_ack},
    // smp = what the cycle's bus value becomes (0 none, 1 fetch, 2 data, 3 UART low byte).
    typedef struct {
        bit          busy;
        bit [4:0]    strb;
        bit          drive;
        logic [15:0] data;
        bit [1:0]    ack;
        int          smp;
    } cyc_t;

    cyc_t        q[$];
    cyc_t        cur;
    bit          mvalid = 1'b0;
    bit          m_last = 1'b0;
    logic [15:0] m_if_rd = 16'h0000;
    logic [15:0] m_d_rd = 16'h0000;
    logic [15:0] m_addr = 16'h0000;

    function automatic cyc_t idle_cyc();
        cyc_t c;
        c.busy = 1'b0; c.strb = 5'h1f; c.drive = 1'b0; c.data = 16'h0000; c.ack = 2'b00; c.smp = 0;
        return c;
    endfunction

    // kind: 0 SRAM read, 1 SRAM write, 2 UART read, 3 UART write
    task automatic push_access(input int kind, input logic [15:0] wd, input int smp);
        cyc_t c;
        for (int i = 0; i <= WAIT; i++) begin
            c = idle_cyc();
            c.busy = 1'b1;
            c.data = wd;
            case (kind)
                0: c.strb = 5'b00111;
                1: begin c.strb = {2'b01, (i == 0 && WAIT > 0), 2'b11}; c.drive = 1'b1; end
                2: c.strb = 5'b11101;
                default: begin c.strb = 5'b11110; c.drive = 1'b1; end
            endcase
            if (i == WAIT) c.smp = smp;
            q.push_back(c);
        end
    endtask

    task automatic push_ack(input bit is_data);
        cyc_t c;
        c = idle_cyc();
        c.busy = 1'b1;
        c.ack = is_data ? 2'b01 : 2'b10;
        q.push_back(c);
    endtask

    task automatic grant();
        if (bus.d_req && !(bus.if_req && m_last)) begin
            m_last = 1'b1;
            m_addr = bus.d_addr;
            if (bus.d_addr == UART_STAT) begin
                if (!bus.d_we) m_d_rd = {14'b0, bus.data_ready, bus.tbre & bus.tsre};
            end else if (bus.d_addr == UART_DATA) begin
                if (bus.d_we) push_access(3, bus.d_wdata, 0);
                else          push_access(2, 16'h0000, 3);
            end else begin
                if (bus.d_we) push_access(1, bus.d_wdata, 0);
                else          push_access(0, 16'h0000, 2);
            end
            push_ack(1'b1);
        end else if (bus.if_req) begin
            m_last = 1'b0;
            m_addr = bus.if_addr;
            push_access(0, 16'h0000, 1);
            push_ack(1'b0);
        end
    endtask

    initial cur = idle_cyc();

    always @(negedge clk) begin
        if (mvalid) begin
            chk("m_busy", 32'(bus.busy), 32'(cur.busy));
            chk("m_strobes", 32'({bus.sram_en, bus.sram_oe, bus.sram_rw, bus.rdn, bus.wrn}), 32'(cur.strb));
            chk("m_acks", 32'({bus.if_ack, bus.d_ack}), 32'(cur.ack));
            chk("m_if_rdata", 32'(bus.if_rdata), 32'(m_if_rd));
            chk("m_d_rdata", 32'(bus.d_rdata), 32'(m_d_rd));
            chk("m_sram_addr", 32'(bus.sram_addr), 32'({2'b00, m_addr}));
            chk("m_bus", 32'(sram_data), 32'(cur.drive ? cur.data : rd_val));
        end
        if (rst) begin
            q.delete();
            cur = idle_cyc();
            m_if_rd = 16'h0000;
            m_d_rd = 16'h0000;
            m_addr = 16'h0000;
            m_last = 1'b0;
            mvalid = 1'b1;
        end else if (mvalid) begin
            case (cur.smp)
                1: m_if_rd = rd_val;
                2: m_d_rd = rd_val;
                3: m_d_rd = {8'h00, rd_val[7:0]};
                default: ;
            endcase
            if (q.size() != 0) begin
                cur = q.pop_front();
            end else if (cur.ack != 2'b00) begin
                cur = idle_cyc();
            end else begin
                grant();
                if (q.size() != 0) cur = q.pop_front();
                else cur = idle_cyc();
            end
        end
        tb_drv = !cur.drive;
    end

    int          n_ack;
    logic [1:0]  seq [0:2];

    initial begin
        bus.if_req = 1'b0; bus.if_addr = 16'h0000;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 16'h0000; bus.d_wdata = 16'h0000;
        bus.tbre = 1'b0; bus.tsre = 1'b0; bus.data_ready = 1'b0;
        n_ack = 0;
        for (int i = 0; i < 3; i++) seq[i] = 2'b00;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_strobes", 32'({bus.sram_en, bus.sram_oe, bus.sram_rw, bus.rdn, bus.wrn}), 32'h1f);
        chk("rst_acks", 32'({bus.if_ack, bus.d_ack}), 32'd0);
        chk("rst_rdata", 32'({bus.if_rdata, bus.d_rdata}), 32'd0);
        chk("rst_addr", 32'(bus.sram_addr), 32'd0);

        // Fetch only
        @(posedge clk); #1;
        bus.if_req = 1'b1; bus.if_addr = 16'h0040; rd_val = 16'h4A03;
        @(negedge clk);
        @(negedge clk);
        chk("fetch_oe_c1", 32'(bus.sram_oe), 32'd0);
        chk("fetch_addr", 32'(bus.sram_addr), 32'h00040);
        @(negedge clk);
        chk("fetch_oe_c2", 32'(bus.sram_oe), 32'd0);
        @(negedge clk);
        chk("fetch_ack", 32'({bus.if_ack, bus.d_ack}), 32'b10);
        chk("fetch_rdata", 32'(bus.if_rdata), 32'h4A03);
        @(posedge clk); #1;
        bus.if_req = 1'b0;
        @(negedge clk);

        // Contention: data write first, then fetch
        @(posedge clk); #1;
        bus.if_req = 1'b1; bus.if_addr = 16'h0100;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h8000; bus.d_wdata = 16'h1234;
        @(negedge clk);
        @(negedge clk);
        chk("wr_rw_c1", 32'(bus.sram_rw), 32'd1);
        @(negedge clk);
        chk("wr_rw_c2", 32'(bus.sram_rw), 32'd0);
        chk("wr_bus", 32'(sram_data), 32'h1234);
        @(negedge clk);
        chk("wr_dack", 32'({bus.if_ack, bus.d_ack}), 32'b01);
        @(posedge clk); #1;
        bus.d_req = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        chk("ctn_if_ack", 32'({bus.if_ack, bus.d_ack}), 32'b10);
        @(posedge clk); #1;
        bus.if_req = 1'b0;
        @(negedge clk);

        // Fairness: both held, grants alternate starting with data
        @(posedge clk); #1;
        bus.if_req = 1'b1; bus.if_addr = 16'h0300;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0200;
        for (int c = 0; c < 20 && n_ack < 3; c++) begin
            @(negedge clk);
            if (bus.if_ack || bus.d_ack) begin
                seq[n_ack] = {bus.if_ack, bus.d_ack};
                n_ack++;
            end
        end
        chk("fair_count", 32'(n_ack), 32'd3);
        chk("fair_g0", 32'(seq[0]), 32'b01);
        chk("fair_g1", 32'(seq[1]), 32'b10);
        chk("fair_g2", 32'(seq[2]), 32'b01);
        @(posedge clk); #1;
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        repeat (5) @(negedge clk);

        // UART status read, then UART data write
        @(posedge clk); #1;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = UART_STAT;
        bus.data_ready = 1'b1; bus.tbre = 1'b1; bus.tsre = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("stat_ack", 32'({bus.if_ack, bus.d_ack}), 32'b01);
        chk("stat_rdata", 32'(bus.d_rdata), 32'h0003);
        chk("stat_strobes", 32'({bus.sram_en, bus.sram_oe, bus.sram_rw, bus.rdn, bus.wrn}), 32'h1f);
        @(posedge clk); #1;
        bus.d_we = 1'b1; bus.d_addr = UART_DATA; bus.d_wdata = 16'h0041;
        @(negedge clk);
        @(negedge clk);
        chk("uwr_c1", 32'({bus.wrn, bus.sram_en}), 32'b01);
        chk("uwr_bus", 32'(sram_data), 32'h0041);
        @(negedge clk);
        chk("uwr_c2", 32'({bus.wrn, bus.sram_en}), 32'b01);
        @(negedge clk);
        chk("uwr_ack", 32'({bus.if_ack, bus.d_ack}), 32'b01);
        @(posedge clk); #1;
        bus.d_req = 1'b0;
        @(negedge clk);

        // Reset in the middle of an SRAM read
        @(posedge clk); #1;
        bus.if_req = 1'b1; bus.if_addr = 16'h0500;
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_mrd", 32'(bus.sram_oe), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1; bus.if_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_oe", 32'(bus.sram_oe), 32'd1);
        chk("abort_if_rdata", 32'(bus.if_rdata), 32'd0);
        for (int c = 0; c < 4; c++) begin
            chk("abort_no_ack", 32'(bus.if_ack), 32'd0);
            @(negedge clk);
        end

        // Random traffic
        repeat (3000) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 149) == 0);
            bus.if_req = ($urandom_range(0, 3) != 0);
            bus.if_addr = 16'($urandom);
            bus.d_req = ($urandom_range(0, 2) != 0);
            bus.d_we = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: bus.d_addr = UART_DATA;
                1: bus.d_addr = UART_STAT;
                default: bus.d_addr = 16'($urandom);
            endcase
            bus.d_wdata = 16'($urandom);
            bus.tbre = 1'($urandom_range(0, 1));
            bus.tsre = 1'($urandom_range(0, 1));
            bus.data_ready = 1'($urandom_range(0, 1));
            rd_val = 16'($urandom);
        end
        @(posedge clk); #1;
        rst = 1'b0; bus.if_req = 1'b0; bus.d_req = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter WAIT, default 1: extra strobe cycles per SRAM/UART access (range 0..7).
REQ-002 Parameter UART_DATA, default 16'hBF00: UART data address.
REQ-003 Parameter UART_STAT, default 16'hBF01: UART status address.
REQ-004 CLK  in  1  system clock; all state updates on rising edge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 if_req  in  1  instruction-fetch request, held until if_ack.
REQ-007 if_addr  in  16  fetch word address.
REQ-008 if_ack  out  1  one-cycle pulse; if_rdata valid this cycle.
REQ-009 if_rdata  out  16  fetched instruction, held until next fetch completes.
REQ-010 d_req  in  1  MEM-stage data request, held until d_ack.
REQ-011 d_we  in  1  1 = write, 0 = read.
REQ-012 d_addr  in  16  data word address.
REQ-013 d_wdata  in  16  write data.
REQ-014 d_ack  out  1  one-cycle completion pulse.
REQ-015 d_rdata  out  16  read data, valid with d_ack, held until next data read completes.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 sram_addr  out  18  {2'b00, granted address}.
REQ-018 sram_data  inout  16  shared SRAM/UART bus.
REQ-019 sram_en, sram_oe, sram_rw  out  1 each  SRAM strobes, active-low.
REQ-020 tbre, tsre, data_ready  in  1 each  UART status.
REQ-021 rdn, wrn  out  1 each  UART strobes, active-low.

Function
REQ-022 FSM states: IDLE, MRD, MWR, URD, UWR, ACK.
REQ-023 Grant is evaluated only in IDLE. Data beats fetch, except fetch wins when the previous grant was data and both are pending.
REQ-024 Grant decode: data to UART_STAT goes straight to ACK; data to UART_DATA goes to URD (read) or UWR (write). All other data reads and all fetches go to MRD; other data writes go to MWR.
REQ-025 Granted address, write data and requester identity are latched at grant; later input changes are ignored until ACK.
REQ-026 MRD lasts WAIT+1 cycles: sram_en=0, sram_oe=0, sram_rw=1. sram_data is sampled on the last MRD cycle.
REQ-027 MWR lasts WAIT+1 cycles: sram_en=0, sram_oe=1, latched data driven. sram_rw=1 on the first cycle and 0 on the remaining WAIT cycles; if WAIT=0, sram_rw=0 for the single cycle.
REQ-028 URD lasts WAIT+1 cycles: rdn=0, sram_en=1. Result is {8'h00, sram_data[7:0]} sampled on the last cycle.
REQ-029 UWR lasts WAIT+1 cycles: wrn=0, sram_en=1, latched data driven.
REQ-030 Status read result is {14'b0, data_ready, tbre & tsre}, sampled at grant.
REQ-031 ACK lasts exactly one cycle: pulses the ack of the granted requester only, updates that requester's rdata on reads, then returns to IDLE. No new grant is made in ACK.
REQ-032 Latency from request seen in IDLE to ack: SRAM/UART access WAIT+2 cycles (3 at default); status read 1 cycle.
REQ-033 sram_data is driven only in MWR and UWR, high-Z otherwise. In every other state all active-low strobes are 1.
REQ-034 A request deasserted mid-access does not abort it; the ack is still issued.
REQ-035 The internal wait counter is 3 bits and reloads on every state entry.

Reset
REQ-036 With RST high at a clock edge, on the following cycle: state IDLE; if_ack=d_ack=busy=0; if_rdata=d_rdata=0; sram_addr=0; all active-low strobes 1; sram_data high-Z; fairness flag cleared so data has priority.
REQ-037 RST asserted mid-access aborts the access; no ack is issued for it.

Verification
REQ-038 Reset: RST for 2 cycles -> strobes all 1, acks 0, busy 0, sram_data Z.
REQ-039 Fetch only: if_req with if_addr=0x0040, SRAM returns 0x4A03 -> sram_oe low 2 cycles, if_ack on cycle 3, if_rdata=0x4A03.
REQ-040 Contention: if_req and d_req (write 0x8000 <- 0x1234) in the same cycle -> write first (sram_rw low 1 cycle, bus 0x1234), d_ack, then fetch, if_ack 3 cycles after IDLE re-entry.
REQ-041 Fairness: d_req held continuously with if_req pending -> grants alternate data, fetch, data.
REQ-042 UART: status read with data_ready=1, tbre=1, tsre=1 -> d_rdata=0x0003 with d_ack 1 cycle after request and no strobes. Then UART write of 0x0041 -> wrn low 2 cycles, sram_en=1, bus 0x0041.
REQ-043 Abort: RST asserted during MRD -> next cycle IDLE, sram_oe=1, no if_ack.
